proyecto_1: RTL and testbench

- Fire/gas safety monitor controller.
- Classifies a smoke sensor (humo), a temperature switch (temp) and a 4-bit CO level (cor) into NORMAL, PREVENCION or ALERTA.
- Drives three status LEDs and two buzzer outputs.
- Multiplexes a 4-digit common-anode 7-segment display showing the state letter and the CO level.
- Master enable is the interruptor switch.

---
 rtl/proyecto_1.sv | 246 ++++++++++++++++++++++++
 tb/tb_proyecto_1.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proyecto_1.sv
// Fire/gas safety monitor: classifies smoke, temperature and CO level into
// NORMAL / PREVENCION / ALERTA, drives LEDs, buzzers and a 4-digit display.
module proyecto_1 #(
    parameter int         DEB_BITS = 16,
    parameter int         REF_BITS = 16,
    parameter int         TONE_BIT = 12,
    parameter logic [3:0] CO_PREV  = 4'd6,
    parameter logic [3:0] CO_ALERT = 4'd12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       interruptor,
    input  logic       temp,
    input  logic       humo,
    input  logic [3:0] cor,
    output logic       LEDalerta,
    output logic       LEDprevencion,
    output logic       LEDnormal,
    output logic       alarma_alerta,
    output logic       alarma_prevencion,
    output logic [3:0] cualdisplay,
    output logic [7:0] display
);

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_NORMAL  = 2'd1,
        ST_PREV    = 2'd2,
        ST_ALERTA  = 2'd3
    } state_t;

    // Two extra bits above the digit select provide the intermittent beep.
    localparam int                  CNT_W   = REF_BITS + 4;
    localparam logic [DEB_BITS-1:0] DEB_MAX = {DEB_BITS{1'b1}};

    logic [6:0]          r_sync_meta;
    logic [6:0]          r_sync;
    logic                w_en;
    logic                w_temp;
    logic                w_humo;
    logic [3:0]          w_cor;
    state_t              w_cand;
    state_t              r_cand_prev;
    state_t              r_state;
    state_t              w_state_nxt;
    logic [DEB_BITS-1:0] r_deb;
    logic                w_deb_done;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          w_digit;
    logic [3:0]          w_ones;
    logic [3:0]          w_tens;
    logic                w_led_a;
    logic                w_led_p;
    logic                w_led_n;
    logic                w_alm_a;
    logic                w_alm_p;
    logic [3:0]          w_sel;
    logic [7:0]          w_seg;
    logic                r_led_a;
    logic                r_led_p;
    logic                r_led_n;
    logic                r_alm_a;
    logic                r_alm_p;
    logic [3:0]          r_sel;
    logic [7:0]          r_seg;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] letter7(input state_t s);
        case (s)
            ST_ALERTA: letter7 = 8'h88;
            ST_PREV:   letter7 = 8'h8C;
            ST_NORMAL: letter7 = 8'hAB;
            default:   letter7 = 8'hFF;
        endcase
    endfunction

    // Two-flop synchronizers for all asynchronous inputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync_meta <= 7'd0;
            r_sync      <= 7'd0;
        end else begin
            r_sync_meta <= {interruptor, temp, humo, cor};
            r_sync      <= r_sync_meta;
        end
    end

    assign w_en   = r_sync[6];
    assign w_temp = r_sync[5];
    assign w_humo = r_sync[4];
    assign w_cor  = r_sync[3:0];

    // Candidate classification, highest priority first
    always_comb begin
        if (w_humo || (w_cor >= CO_ALERT)) begin
            w_cand = ST_ALERTA;
        end else if (w_temp || (w_cor >= CO_PREV)) begin
            w_cand = ST_PREV;
        end else begin
            w_cand = ST_NORMAL;
        end
    end

    // Debounce: counts consecutive cycles with an unchanged candidate
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_deb       <= {DEB_BITS{1'b0}};
            r_cand_prev <= ST_NORMAL;
        end else begin
            r_cand_prev <= w_cand;
            if (!w_en || (r_state == ST_OFF)) begin
                r_deb <= {DEB_BITS{1'b0}};
            end else if (w_cand != r_cand_prev) begin
                r_deb <= {DEB_BITS{1'b0}};
            end else begin
                r_deb <= r_deb + DEB_BITS'(1);
            end
        end
    end

    assign w_deb_done = (r_deb == DEB_MAX) && (w_cand == r_cand_prev);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; disabling the system bypasses debounce
    always_comb begin
        w_state_nxt = r_state;
        if (!w_en) begin
            w_state_nxt = ST_OFF;
        end else begin
            case (r_state)
                ST_OFF: w_state_nxt = ST_NORMAL;
                ST_NORMAL, ST_PREV, ST_ALERTA: begin
                    if (w_deb_done && (w_cand != r_state)) begin
                        w_state_nxt = w_cand;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                default: w_state_nxt = ST_OFF;
            endcase
        end
    end

    // Free-running refresh/tone counter, held at zero while off
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (r_state == ST_OFF) begin
            r_cnt <= {CNT_W{1'b0}};
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_digit = r_cnt[REF_BITS+1:REF_BITS];
    assign w_ones  = (w_cor >= 4'd10) ? (w_cor - 4'd10) : w_cor;
    assign w_tens  = (w_cor >= 4'd10) ? 4'd1 : 4'd0;

    // Output decode from state, counter and live CO level
    always_comb begin
        w_led_a = 1'b0;
        w_led_p = 1'b0;
        w_led_n = 1'b0;
        w_alm_a = 1'b0;
        w_alm_p = 1'b0;
        w_sel   = 4'b1111;
        w_seg   = 8'hFF;
        case (r_state)
            ST_NORMAL: w_led_n = 1'b1;
            ST_PREV: begin
                w_led_p = 1'b1;
                w_alm_p = r_cnt[TONE_BIT] & r_cnt[REF_BITS+3];
            end
            ST_ALERTA: begin
                w_led_a = 1'b1;
                w_alm_a = r_cnt[TONE_BIT];
            end
            default: w_led_n = 1'b0;
        endcase
        if (r_state != ST_OFF) begin
            case (w_digit)
                2'd0: begin w_sel = 4'b1110; w_seg = seg7(w_ones);     end
                2'd1: begin w_sel = 4'b1101; w_seg = seg7(w_tens);     end
                2'd2: begin w_sel = 4'b1011; w_seg = 8'hFF;            end
                2'd3: begin w_sel = 4'b0111; w_seg = letter7(r_state); end
                default: begin w_sel = 4'b1111; w_seg = 8'hFF; end
            endcase
        end else begin
            w_sel = 4'b1111;
            w_seg = 8'hFF;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_led_a <= 1'b0;
            r_led_p <= 1'b0;
            r_led_n <= 1'b0;
            r_alm_a <= 1'b0;
            r_alm_p <= 1'b0;
            r_sel   <= 4'b1111;
            r_seg   <= 8'hFF;
        end else begin
            r_led_a <= w_led_a;
            r_led_p <= w_led_p;
            r_led_n <= w_led_n;
            r_alm_a <= w_alm_a;
            r_alm_p <= w_alm_p;
            r_sel   <= w_sel;
            r_seg   <= w_seg;
        end
    end

    assign LEDalerta         = r_led_a;
    assign LEDprevencion     = r_led_p;
    assign LEDnormal         = r_led_n;
    assign alarma_alerta     = r_alm_a;
    assign alarma_prevencion = r_alm_p;
    assign cualdisplay       = r_sel;
    assign display           = r_seg;

endmodule

// File: tb/tb_proyecto_1.sv
// Self-checking bench for proyecto_1 with shortened debounce/refresh timing.
module tb_proyecto_1;

    localparam int         DEB_BITS = 5;
    localparam int         REF_BITS = 3;
    localparam int         TONE_BIT = 1;
    localparam logic [3:0] CO_PREV  = 4'd6;
    localparam logic [3:0] CO_ALERT = 4'd12;
    localparam int         DEB_N    = 1 << DEB_BITS;
    localparam int         DIG_N    = 1 << REF_BITS;
    localparam int         BEEP_N   = 1 << (REF_BITS + 4);

    // abstract states: 0 off, 1 normal, 2 prevencion, 3 alerta
    localparam int S_OFF = 0, S_NOR = 1, S_PRE = 2, S_ALE = 3;

    logic       clk;
    logic       rst;
    logic       interruptor;
    logic       temp;
    logic       humo;
    logic [3:0] cor;
    logic       LEDalerta, LEDprevencion, LEDnormal;
    logic       alarma_alerta, alarma_prevencion;
    logic [3:0] cualdisplay;
    logic [7:0] display;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    proyecto_1 #(
        .DEB_BITS(DEB_BITS), .REF_BITS(REF_BITS), .TONE_BIT(TONE_BIT),
        .CO_PREV(CO_PREV), .CO_ALERT(CO_ALERT)
    ) dut (
        .clk(clk), .rst(rst), .interruptor(interruptor), .temp(temp),
        .humo(humo), .cor(cor), .LEDalerta(LEDalerta),
        .LEDprevencion(LEDprevencion), .LEDnormal(LEDnormal),
        .alarma_alerta(alarma_alerta), .alarma_prevencion(alarma_prevencion),
        .cualdisplay(cualdisplay), .display(display)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int classify(input bit h, input bit t, input int c);
        if (h || (c >= int'(CO_ALERT))) return S_ALE;
        if (t || (c >= int'(CO_PREV)))  return S_PRE;
        return S_NOR;
    endfunction

    function automatic logic [2:0] leds_of(input int st);
        case (st)
            S_NOR:   return 3'b001;
            S_PRE:   return 3'b010;
            S_ALE:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [7:0] letter_of(input int st);
        case (st)
            S_NOR:   return 8'hAB;
            S_PRE:   return 8'h8C;
            S_ALE:   return 8'h88;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic int sel_idx(input logic [3:0] s);
        case (s)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [2:0] led_now();
        return {LEDalerta, LEDprevencion, LEDnormal};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_leds(input logic [2:0] exp, input int max_cyc, output int cyc);
        cyc = 0;
        while ((led_now() !== exp) && (cyc < max_cyc)) begin
            tick(1);
            cyc++;
        end
    endtask

    task automatic test_display_scan(input int st, input int c, input int ncyc, input string tag);
        int bad = 0, badseq = 0, edges = 0, run = 0, idx, pidx = -1;
        logic [7:0] expv, got_first, exp_first;
        got_first = 8'h00; exp_first = 8'h00;
        for (int i = 0; i < ncyc; i++) begin
            idx = sel_idx(cualdisplay);
            case (idx)
                0:       expv = seg_tab[c % 10];
                1:       expv = seg_tab[c / 10];
                2:       expv = 8'hFF;
                3:       expv = letter_of(st);
                default: expv = 8'hxx;
            endcase
            if ((idx < 0) || (display !== expv)) begin
                if (bad == 0) begin got_first = display; exp_first = expv; end
                bad++;
            end
            if (i > 0 && idx != pidx) begin
                if (edges > 0 && run != DIG_N) badseq++;
                if (idx != ((pidx + 1) % 4)) badseq++;
                edges++;
                run = 1;
            end else begin
                run++;
            end
            pidx = idx;
            tick(1);
        end
        if (ncyc >= 2 * DIG_N && edges == 0) badseq++;
        n_checks++;
        if (bad != 0) $display("FAIL %s_digits: %0d bad cycles, first got %h want %h", tag, bad, got_first, exp_first);
        else n_pass++;
        n_checks++;
        if (badseq != 0) $display("FAIL %s_scan_order: %0d sequencing errors, want 0", tag, badseq);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b0; interruptor = 1'b1; temp = 1'b0; humo = 1'b0; cor = 4'd0;
        tick(10);
        n_checks++;
        if (led_now() !== 3'b000) $display("FAIL reset_leds: got %b want 000", led_now());
        else n_pass++;
        n_checks++;
        if ({alarma_alerta, alarma_prevencion} !== 2'b00)
            $display("FAIL reset_alarms: got %b want 00", {alarma_alerta, alarma_prevencion});
        else n_pass++;
        n_checks++;
        if (cualdisplay !== 4'b1111 || display !== 8'hFF)
            $display("FAIL reset_display: got %b/%h want 1111/ff", cualdisplay, display);
        else n_pass++;
    endtask

    task automatic test_startup();
        int cyc;
        rst = 1'b1;
        wait_leds(3'b001, 6, cyc);
        n_checks++;
        if (led_now() !== 3'b001) $display("FAIL startup_normal: got %b want 001 after %0d cycles", led_now(), cyc);
        else n_pass++;
        n_checks++;
        if ({alarma_alerta, alarma_prevencion} !== 2'b00)
            $display("FAIL startup_alarms: got %b want 00", {alarma_alerta, alarma_prevencion});
        else n_pass++;
        test_display_scan(S_NOR, 0, 4 * DIG_N + 4, "startup");
    endtask

    task automatic test_interruptor();
        int cyc, bad = 0;
        interruptor = 1'b0;
        wait_leds(3'b000, 6, cyc);
        for (int i = 0; i < 100; i++) begin
            if (led_now() !== 3'b000 || alarma_alerta !== 1'b0 || alarma_prevencion !== 1'b0 ||
                cualdisplay !== 4'b1111 || display !== 8'hFF) bad++;
            tick(1);
        end
        n_checks++;
        if (bad != 0) $display("FAIL off_outputs: %0d cycles not at off values (took %0d to drop), want 0", bad, cyc);
        else n_pass++;
        interruptor = 1'b1;
        wait_leds(3'b001, 6, cyc);
        n_checks++;
        if (led_now() !== 3'b001) $display("FAIL resume_normal: got %b want 001", led_now());
        else n_pass++;
    endtask

    task automatic test_alert_debounce();
        int cyc, bad = 0, first = -1, pbad = 0, tbad = 0;
        logic s [48];
        humo = 1'b1;
        tick(20);
        humo = 1'b0;
        for (int i = 0; i < DEB_N + 20; i++) begin
            if (led_now() !== 3'b001) bad++;
            tick(1);
        end
        n_checks++;
        if (bad != 0) $display("FAIL glitch_ignored: %0d cycles left NORMAL, want 0", bad);
        else n_pass++;
        humo = 1'b1;
        wait_leds(3'b100, DEB_N + 8, cyc);
        n_checks++;
        if (led_now() !== 3'b100 || cyc < DEB_N)
            $display("FAIL alert_debounce: leds %b after %0d cycles, want 100 within [%0d,%0d]", led_now(), cyc, DEB_N, DEB_N + 8);
        else n_pass++;
        for (int i = 0; i < 48; i++) begin
            s[i] = alarma_alerta;
            if (alarma_prevencion !== 1'b0) pbad++;
            tick(1);
        end
        for (int i = 1; i < 48 && first < 0; i++) if (s[i] !== s[i-1]) first = i;
        if (first < 0) tbad = 1;
        else for (int j = first; j < 48; j++)
            if (s[j] !== (s[first] ^ 1'(((j - first) >> TONE_BIT) & 1))) tbad++;
        n_checks++;
        if (tbad != 0) $display("FAIL alert_tone: %0d samples off the 2^TONE_BIT toggle pattern, want 0", tbad);
        else n_pass++;
        n_checks++;
        if (pbad != 0) $display("FAIL alert_prev_quiet: alarma_prevencion high %0d cycles, want 0", pbad);
        else n_pass++;
        test_display_scan(S_ALE, 0, 4 * DIG_N + 4, "alert");
    endtask

    task automatic test_prevencion();
        int cyc, highs = 0, abad = 0, runbad = 0, run = 0;
        humo = 1'b0; temp = 1'b1;
        wait_leds(3'b010, DEB_N + 8, cyc);
        n_checks++;
        if (led_now() !== 3'b010) $display("FAIL prev_state: got %b want 010", led_now());
        else n_pass++;
        for (int i = 0; i < BEEP_N; i++) begin
            if (alarma_prevencion === 1'b1) begin highs++; run++; end
            else begin
                if (run != 0 && run != (1 << TONE_BIT)) runbad++;
                run = 0;
            end
            if (alarma_alerta !== 1'b0) abad++;
            tick(1);
        end
        n_checks++;
        if (highs != BEEP_N / 4 || runbad != 0)
            $display("FAIL prev_tone: %0d high cycles (%0d bad pulses), want %0d (0)", highs, runbad, BEEP_N / 4);
        else n_pass++;
        n_checks++;
        if (abad != 0) $display("FAIL prev_alert_quiet: alarma_alerta high %0d cycles, want 0", abad);
        else n_pass++;
        test_display_scan(S_PRE, 0, 4 * DIG_N + 4, "prev");
    endtask

    task automatic test_cor();
        int cyc;
        temp = 1'b0; cor = 4'd15;
        wait_leds(3'b100, DEB_N + 8, cyc);
        n_checks++;
        if (led_now() !== 3'b100) $display("FAIL cor15_alert: got %b want 100", led_now());
        else n_pass++;
        test_display_scan(S_ALE, 15, 4 * DIG_N + 4, "cor15");
        cor = 4'd1;
        tick(4);
        test_display_scan(S_ALE, 1, 3 * DIG_N, "cor1_live");
        wait_leds(3'b001, DEB_N + 8, cyc);
        n_checks++;
        if (led_now() !== 3'b001) $display("FAIL cor1_normal: got %b want 001", led_now());
        else n_pass++;
    endtask

    task automatic test_random();
        int st;
        bit h, t;
        int c;
        for (int k = 0; k < 12; k++) begin
            h = 1'($urandom_range(0, 3) == 0);
            t = 1'($urandom_range(0, 2) == 0);
            c = int'($urandom_range(0, 15));
            humo = h; temp = t; cor = 4'(c);
            st = classify(h, t, c);
            tick(DEB_N + 12);
            n_checks++;
            if (led_now() !== leds_of(st))
                $display("FAIL random_%0d_leds: h=%0d t=%0d cor=%0d got %b want %b", k, h, t, c, led_now(), leds_of(st));
            else n_pass++;
            test_display_scan(st, c, 4 * DIG_N + 2, "random");
        end
    endtask

    task automatic test_priority_reset();
        int cyc;
        humo = 1'b1; temp = 1'b1; cor = 4'd3;
        tick(4);
        wait_leds(3'b100, DEB_N + 8, cyc);
        n_checks++;
        if (led_now() !== 3'b100) $display("FAIL priority_alert: got %b want 100", led_now());
        else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (led_now() !== 3'b000 || {alarma_alerta, alarma_prevencion} !== 2'b00 ||
            cualdisplay !== 4'b1111 || display !== 8'hFF)
            $display("FAIL async_reset: leds %b alarms %b sel %b disp %h want 000 00 1111 ff",
                     led_now(), {alarma_alerta, alarma_prevencion}, cualdisplay, display);
        else n_pass++;
        tick(3);
        rst = 1'b1;
        wait_leds(3'b001, 6, cyc);
        n_checks++;
        if (led_now() !== 3'b001) $display("FAIL post_reset_normal: got %b want 001", led_now());
        else n_pass++;
        wait_leds(3'b100, DEB_N + 8, cyc);
        n_checks++;
        if (led_now() !== 3'b100) $display("FAIL post_reset_alert: got %b want 100", led_now());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_startup();
        test_interruptor();
        test_alert_debounce();
        test_prevencion();
        test_cor();
        test_random();
        test_priority_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
